fifo_sync_flags: RTL and testbench
==================================

Name: fifo_sync_flags

Overview:
- Single-clock, parametrised synchronous FIFO: successor to the current minilab FIFO wrapper.
- Adds a selectable read mode (registered or first-word-fall-through), an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a synchronous flush.
- Sits between producer/consumer stages in the minilab datapaths. Storage is an inferred register array; no vendor IP.

Parameters:
DEPTH, 8, number of entries; power of 2, >= 2
DATA_WIDTH, 8, width of each entry in bits
FWFT, 0, read mode: 0 = registered read (data 1 cycle after rden); 1 = first-word-fall-through (head visible on o_data)
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous flush; empties FIFO and clears error flags
wren  input  1  write request
i_data  input  DATA_WIDTH  write data
rden  input  1  read request (FWFT=1: pop head)
o_data  output  DATA_WIDTH  read data
o_valid  output  1  o_data holds valid read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=1, async): write/read pointers, count, overflow, underflow, o_valid and o_data go to 0. empty=1, full=0, almost_empty=1 (AE_THRESH >= 0), almost_full=0. Memory contents are not reset. Reset mid-operation discards all entries.
- Pointers: $clog2(DEPTH) bits; they wrap from DEPTH-1 to 0 naturally. count is a registered counter, not derived from pointer difference.
- Write acceptance: wr_ok = wren & ~full. On wr_ok: mem[wptr] <= i_data, wptr++.
- Read acceptance: rd_ok = rden & ~empty. On rd_ok: rptr++.
- Write and read acceptance are evaluated against the current-cycle flags. A write is rejected when full, even if a read is accepted in the same cycle. A read is rejected when empty, even if a write occurs in the same cycle.
- count update: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
- All flags are combinational compares of the registered count, so they are glitch-free relative to clk and update the cycle after the causing edge.
- FWFT=0 read path:
  - On rd_ok, o_data <= mem[rptr] and o_valid <= 1 at the same edge, so data and o_valid appear 1 cycle after rden.
  - Otherwise o_valid <= 0 and o_data holds its last value.
- FWFT=1 read path:
  - o_data = mem[rptr] (combinational) and o_valid = ~empty.
  - rden while o_valid pops the head. The next entry appears on the same cycle rptr advances.
  - A write into an empty FIFO is visible on o_data/o_valid the cycle after the write edge.
- overflow <= 1 on any cycle with wren & full. underflow <= 1 on any cycle with rden & empty. Both stay set until clr or rst.
- clr (sync): pointers, count, overflow, underflow and o_valid go to 0; o_data goes to 0 in FWFT=0 mode. clr overrides wren/rden in the same cycle: no write is stored, no read is performed, and no error flag is set.
- Illegal parameter values (DEPTH not a power of 2, thresholds out of range) are caught by an elaboration-time check that raises $error.

Test Plan (DEPTH=8, DATA_WIDTH=8, AF_THRESH=6, AE_THRESH=1 unless stated):
- Reset/fill: rst pulse, then write 0x10..0x17 on 8 consecutive cycles.
  - Expect count 1..8 stepping each cycle; almost_empty drops when count=2; almost_full rises at count=6; full=1 at count=8; overflow stays 0.
- Overflow and wrap (FWFT=0): with the FIFO full, write 0xAA → count stays 8 and overflow=1 (sticky). Then read 8 times → o_data 0x10..0x17 each 1 cycle after rden, o_valid pulsing per read, empty=1 at the end.
  - Then write 0x20..0x23 and read them back → 0x20..0x23, confirming pointer wrap.
- Simultaneous access:
  - At count=3, wren and rden together for 4 cycles → count stays 3 and FIFO order is preserved.
  - At count=0, wren+rden together → write only, count=1, underflow=1.
  - At count=8, wren+rden together → read only, count=7, overflow=1.
- FWFT=1: write 0x55 to an empty FIFO → next cycle o_valid=1, o_data=0x55. Write 0x66, then assert rden → o_data=0x66 on the following cycle. Second rden → o_valid=0, empty=1.
- Flush: at count=5 with overflow=1, assert clr together with wren=1 (data 0x99) → next cycle count=0, empty=1, overflow=0, underflow=0, o_valid=0. A subsequent read does not return 0x99.
- Async reset mid-burst: assert rst between clock edges during back-to-back writes → outputs go to reset values immediately, without waiting for the next clk edge. After release, the first write 0x01 is read back as 0x01.

Source files
------------

// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - single-clock FIFO with selectable read mode, occupancy count and status flags
//
// Parameters:
//   DEPTH       number of entries (power of 2, >= 2)
//   DATA_WIDTH  width of each entry in bits
//   FWFT        0 = registered read (data one cycle after rden)
//               1 = first-word-fall-through (head shown on o_data)
//   AF_THRESH   almost_full when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH   almost_empty when count <= AE_THRESH (0..DEPTH-1)
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           asynchronous active-high reset
//   clr           synchronous flush: empties the FIFO and clears error flags
//   wren, i_data  write request and write data
//   rden          read request (pops the head in FWFT mode)
//   o_data        read data
//   o_valid       o_data holds valid read data
//   full, empty   count == DEPTH / count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         current occupancy, 0..DEPTH
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty

module fifo_sync_flags #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wren,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    rden,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL  = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LVL  = CW'(AE_THRESH);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_sync_flags: DEPTH must be a power of 2 and >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $error("fifo_sync_flags: AF_THRESH must be in 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
        $error("fifo_sync_flags: AE_THRESH must be in 0..DEPTH-1");
    end
    if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
        $error("fifo_sync_flags: FWFT must be 0 or 1");
    end

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [CW-1:0]         cnt_q;
    logic                  ovf_q;
    logic                  unf_q;

    // Flags are pure compares of the registered count, so they only ever
    // change just after a clock edge.
    assign full         = (cnt_q == CNT_MAX);
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= AF_LVL);
    assign almost_empty = (cnt_q <= AE_LVL);
    assign count        = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // Acceptance uses this cycle's flags only: a simultaneous read does not
    // make room for a write when full, and a simultaneous write does not
    // supply data for a read when empty. A flush suppresses both.
    logic wr_ok;
    logic rd_ok;
    assign wr_ok = wren & ~full  & ~clr;
    assign rd_ok = rden & ~empty & ~clr;

    // Memory is intentionally not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            mem[wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_ok) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
            if (wren && full) begin
                ovf_q <= 1'b1;
            end
            if (rden && empty) begin
                unf_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    if (FWFT == 0) begin : g_reg_read
        // Data and valid land together one edge after an accepted read;
        // o_data keeps its last value when no read is accepted.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                o_data  <= '0;
                o_valid <= 1'b0;
            end else if (clr) begin
                o_data  <= '0;
                o_valid <= 1'b0;
            end else if (rd_ok) begin
                o_data  <= mem[rptr];
                o_valid <= 1'b1;
            end else begin
                o_valid <= 1'b0;
            end
        end
    end else begin : g_fwft_read
        // Head entry is shown directly. While empty the output is forced to
        // zero so stale or never-written memory never leaks out, which also
        // gives a clean zero on reset.
        assign o_valid = ~empty;
        assign o_data  = empty ? '0 : mem[rptr];
    end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb/tb_fifo_sync_flags.sv - bench for fifo_sync_flags, registered and FWFT instances against a queue model

module tb_fifo_sync_flags;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          wren;
    logic          rden;
    logic [DW-1:0] i_data;

    logic [DW-1:0] o_data0, o_data1;
    logic          o_valid0, o_valid1;
    logic          full0, full1, empty0, empty1;
    logic          af0, af1, ae0, ae1;
    logic [3:0]    count0, count1;
    logic          ovf0, ovf1, unf0, unf1;

    always #5 clk = ~clk;

    fifo_sync_flags #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut_reg (
        .clk(clk), .rst(rst), .clr(clr), .wren(wren), .i_data(i_data), .rden(rden),
        .o_data(o_data0), .o_valid(o_valid0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(unf0)
    );

    fifo_sync_flags #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut_fwft (
        .clk(clk), .rst(rst), .clr(clr), .wren(wren), .i_data(i_data), .rden(rden),
        .o_data(o_data1), .o_valid(o_valid1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(unf1)
    );

    // Behavioural model: contents as a queue, sticky flags, and the
    // registered-mode output pair.
    logic [DW-1:0] q [$];
    bit            m_ovf;
    bit            m_unf;
    bit            m_v0;
    logic [DW-1:0] m_d0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_unf = 0;
        m_v0  = 0;
        m_d0  = '0;
    endtask

    task automatic model_edge(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
        bit is_full;
        bit is_empty;
        if (rst) begin
            model_reset();
            return;
        end
        if (c) begin
            model_reset();
            return;
        end
        is_full  = (q.size() == DEPTH);
        is_empty = (q.size() == 0);
        if (w && is_full)  m_ovf = 1;
        if (r && is_empty) m_unf = 1;
        if (r && !is_empty) begin
            m_d0 = q.pop_front();
            m_v0 = 1;
        end else begin
            m_v0 = 0;
        end
        if (w && !is_full) q.push_back(d);
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("count_reg",  32'(count0), 32'(sz));
        chk("count_fwft", 32'(count1), 32'(sz));
        chk("full",       32'({full0, full1}),   {30'd0, {2{sz == DEPTH}}});
        chk("empty",      32'({empty0, empty1}), {30'd0, {2{sz == 0}}});
        chk("almost_full",  32'({af0, af1}), {30'd0, {2{sz >= AF}}});
        chk("almost_empty", 32'({ae0, ae1}), {30'd0, {2{sz <= AE}}});
        chk("overflow",   32'({ovf0, ovf1}), {30'd0, {2{m_ovf}}});
        chk("underflow",  32'({unf0, unf1}), {30'd0, {2{m_unf}}});
        chk("o_valid_reg", 32'(o_valid0), 32'(m_v0));
        chk("o_data_reg",  32'(o_data0),  32'(m_d0));
        chk("o_valid_fwft", 32'(o_valid1), 32'(sz != 0));
        chk("o_data_fwft",  32'(o_data1),  (sz != 0) ? 32'(q[0]) : 32'd0);
    endtask

    task automatic step(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
        wren   = w;
        rden   = r;
        clr    = c;
        i_data = d;
        @(posedge clk);
        model_edge(w, r, c, d);
        #1;
        check_all();
    endtask

    initial begin
        rst    = 1'b1;
        clr    = 1'b0;
        wren   = 1'b0;
        rden   = 1'b0;
        i_data = '0;
        model_reset();
        #3;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill 0x10..0x17
        for (int i = 0; i < 8; i++) step(1, 0, 0, 8'(8'h10 + i));
        chk("fill_count", 32'(count0), 32'd8);
        chk("fill_ovf",   32'(ovf0),   32'd0);

        // Overflow while full
        step(1, 0, 0, 8'hAA);
        chk("ovf_set", 32'(ovf0), 32'd1);

        // Drain with read data checked one cycle after rden
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 8'h00);
            chk("drain_data", 32'(o_data0), 32'(8'h10 + i));
        end
        step(0, 0, 0, 8'h00);
        chk("drain_empty", 32'(empty0), 32'd1);

        // Pointer wrap
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'h20 + i));
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 8'h00);
            chk("wrap_data", 32'(o_data0), 32'(8'h20 + i));
        end

        // Simultaneous access at count 3
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(8'h30 + i));
        for (int i = 0; i < 4; i++) step(1, 1, 0, 8'(8'h40 + i));
        chk("simul_count", 32'(count0), 32'd3);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);

        // Simultaneous at empty: write only, underflow
        step(1, 1, 0, 8'h50);
        chk("simul_empty_count", 32'(count0), 32'd1);
        chk("simul_empty_unf",   32'(unf0),   32'd1);

        // Simultaneous at full: read only, overflow
        for (int i = 0; i < 7; i++) step(1, 0, 0, 8'(8'h51 + i));
        step(1, 1, 0, 8'h5F);
        chk("simul_full_count", 32'(count0), 32'd7);
        chk("simul_full_ovf",   32'(ovf0),   32'd1);

        // Flush at count 5 with overflow set, together with a write
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        chk("pre_flush_count", 32'(count0), 32'd5);
        step(1, 0, 1, 8'h99);
        chk("flush_count", 32'(count0), 32'd0);
        chk("flush_ovf",   32'(ovf0),   32'd0);
        step(0, 1, 0, 8'h00);
        chk("flush_no_99", 32'(o_valid0), 32'd0);
        step(0, 0, 1, 8'h00);

        // FWFT behaviour
        step(1, 0, 0, 8'h55);
        chk("fwft_first", 32'({o_valid1, o_data1}), 32'h155);
        step(1, 0, 0, 8'h66);
        step(0, 1, 0, 8'h00);
        chk("fwft_next", 32'({o_valid1, o_data1}), 32'h166);
        step(0, 1, 0, 8'h00);
        chk("fwft_done", 32'({o_valid1, empty1}), 32'h1);

        // Asynchronous reset in the middle of a write burst
        step(1, 0, 0, 8'h30);
        step(1, 0, 0, 8'h31);
        wren   = 1'b1;
        i_data = 8'h32;
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        step(1, 0, 0, 8'h01);
        step(0, 1, 0, 8'h00);
        chk("post_reset_data", 32'(o_data0), 32'h01);

        // Randomised traffic, alternating write-heavy and read-heavy phases
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = ((i / 50) % 2 == 0) ? 70 : 30;
            step($urandom_range(0, 99) < wp,
                 $urandom_range(0, 99) < (100 - wp),
                 $urandom_range(0, 99) < 2,
                 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
